rsa_byte_bridge: RTL and testbench

RSA_BYTE_BRIDGE -- requirements
Module: rsa_byte_bridge

---
 rtl/rsa_byte_bridge.sv | 110 +++++++++++
 tb/tb_rsa_byte_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_byte_bridge.sv
// rsa_byte_bridge: byte-stream loader for an RSA core (n, d, a in; a^d mod n out).
// Optional RSA_BRIDGE_REKEY_EN: reload n and d for every message instead of keeping them.
module rsa_byte_bridge #(
    parameter int OUT_BYTES = 31
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    output logic [255:0] o_core_n,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_a,
    output logic         o_core_start,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished,
    output logic         o_busy
);
    typedef enum logic [2:0] {S_GET_N, S_GET_D, S_GET_A, S_WAIT, S_SEND} state_t;

`ifdef RSA_BRIDGE_REKEY_EN
    localparam state_t S_NEXT = S_GET_N;
`else
    localparam state_t S_NEXT = S_GET_A;
`endif

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d, tx_cnt_q, tx_cnt_d;
    logic [255:0] n_q, n_d, d_q, d_d, a_q, a_d, res_q, res_d;
    logic         start_q, start_d;
    logic         live_q;
    logic         loading, rx_fire, tx_fire;

    always_comb begin
        loading      = state_q inside {S_GET_N, S_GET_D, S_GET_A};
        o_rx_ready   = live_q && loading;
        rx_fire      = i_rx_valid && o_rx_ready;
        o_tx_valid   = state_q == S_SEND;
        tx_fire      = o_tx_valid && i_tx_ready;
        // result is shifted left per sent byte, so the next byte is always at the top of the window
        o_tx_data    = o_tx_valid ? res_q[OUT_BYTES*8-1 -: 8] : 8'h00;
        o_busy       = state_q inside {S_WAIT, S_SEND};
        o_core_n     = n_q;
        o_core_d     = d_q;
        o_core_a     = a_q;
        o_core_start = start_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_cnt_d = tx_cnt_q;
        n_d      = n_q;
        d_d      = d_q;
        a_d      = a_q;
        res_d    = res_q;
        start_d  = 1'b0;
        if (rx_fire) begin
            cnt_d = cnt_q + 5'd1;
            n_d   = (state_q == S_GET_N) ? {n_q[247:0], i_rx_data} : n_q;
            d_d   = (state_q == S_GET_D) ? {d_q[247:0], i_rx_data} : d_q;
            a_d   = (state_q == S_GET_A) ? {a_q[247:0], i_rx_data} : a_q;
            if (cnt_q == 5'd31) begin
                state_d = (state_q == S_GET_N) ? S_GET_D :
                          (state_q == S_GET_D) ? S_GET_A : S_WAIT;
                start_d = state_q == S_GET_A;
            end
        end
        if (state_q == S_WAIT && i_core_finished) begin
            res_d    = i_core_result;
            tx_cnt_d = 5'd0;
            state_d  = S_SEND;
        end
        if (tx_fire) begin
            res_d    = res_q << 8;
            tx_cnt_d = tx_cnt_q + 5'd1;
            if (tx_cnt_q == 5'(OUT_BYTES - 1)) begin
                tx_cnt_d = 5'd0;
                state_d  = S_NEXT;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_GET_N;
            cnt_q    <= 5'd0;
            tx_cnt_q <= 5'd0;
            n_q      <= '0;
            d_q      <= '0;
            a_q      <= '0;
            res_q    <= '0;
            start_q  <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_cnt_q <= tx_cnt_d;
            n_q      <= n_d;
            d_q      <= d_d;
            a_q      <= a_d;
            res_q    <= res_d;
            start_q  <= start_d;
            live_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rsa_byte_bridge.sv
// tb_rsa_byte_bridge: scoreboard bench; stimulus pushes expected starts/bytes, negedge monitor checks.
module tb_rsa_byte_bridge;
    localparam int OB = 31;
    localparam logic [255:0] N    = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
    localparam logic [255:0] D    = 256'h0097A8E6DA3E9DDAF2FC7B4F4D4DF0E3D2D4C3B1E9F02B7C4D8A1E6F5B2C3D4E;
    localparam logic [255:0] A    = 256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;
    localparam logic [255:0] A2   = 256'hDEADBEEFDEADBEEFDEADBEEFDEADBEEFDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    localparam logic [255:0] RES  = 256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF;
    localparam logic [255:0] RES2 = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [7:0]   i_rx_data = 8'h00;
    logic         i_rx_valid = 1'b0;
    logic         o_rx_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready = 1'b0;
    logic [255:0] o_core_n, o_core_d, o_core_a;
    logic         o_core_start;
    logic [255:0] i_core_result = '0;
    logic         i_core_finished = 1'b0;
    logic         o_busy;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;
    logic start_prev = 1'b0;
    logic [7:0]   exp_tx[$];
    logic [255:0] exp_n[$], exp_d[$], exp_a[$];

    rsa_byte_bridge #(.OUT_BYTES(OB)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_core_n(o_core_n), .o_core_d(o_core_d), .o_core_a(o_core_a),
        .o_core_start(o_core_start), .i_core_result(i_core_result),
        .i_core_finished(i_core_finished), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_tx_valid && i_tx_ready) begin
            if (exp_tx.size() == 0) chk("tx_extra", 256'd1, 256'd0);
            else chk("tx_byte", {248'd0, o_tx_data}, {248'd0, exp_tx.pop_front()});
        end
        if (o_core_start) begin
            starts++;
            chk("start_single", {255'd0, start_prev}, 256'd0);
            if (exp_n.size() == 0) chk("start_extra", 256'd1, 256'd0);
            else begin
                chk("core_n", o_core_n, exp_n.pop_front());
                chk("core_d", o_core_d, exp_d.pop_front());
                chk("core_a", o_core_a, exp_a.pop_front());
            end
        end
        start_prev = o_core_start;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int n = 0;
        if (gaps) begin
            i_rx_valid = 1'b0;
            i_rx_data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        do begin
            acc = o_rx_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("rx_timeout", 256'd0, 256'd1);
        i_rx_valid = 1'b0;
    endtask

    task automatic load(input logic [255:0] v, input int nb, input bit gaps);
        for (int i = 0; i < nb; i++) send_byte(v[255-8*i -: 8], gaps);
    endtask

    task automatic expect_start(input logic [255:0] n, input logic [255:0] d, input logic [255:0] a);
        exp_n.push_back(n);
        exp_d.push_back(d);
        exp_a.push_back(a);
    endtask

    task automatic push_res(input logic [255:0] r);
        for (int i = 0; i < OB; i++) exp_tx.push_back(r[(OB-1-i)*8 +: 8]);
    endtask

    task automatic pulse_finish(input logic [255:0] r);
        i_core_result   = r;
        i_core_finished = 1'b1;
        tick();
        i_core_finished = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_tx.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_done", {255'd0, exp_tx.size() == 0}, 256'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] hold;
        repeat (2) tick();
        chk("rst_rx_ready", {255'd0, o_rx_ready}, 256'd0);
        chk("rst_tx_valid", {255'd0, o_tx_valid}, 256'd0);
        chk("rst_start", {255'd0, o_core_start}, 256'd0);
        chk("rst_busy", {255'd0, o_busy}, 256'd0);
        chk("rst_tx_data", {248'd0, o_tx_data}, 256'd0);
        chk("rst_core_n", o_core_n, 256'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("ready_before_edge", {255'd0, o_rx_ready}, 256'd0);
        tick();
        chk("ready_after_edge", {255'd0, o_rx_ready}, 256'd1);

        expect_start(N, D, A);
        load(N, 32, 1'b0);
        load(D, 32, 1'b0);
        load(A, 32, 1'b0);
        chk("start_k1", {255'd0, o_core_start}, 256'd1);
        chk("busy_wait", {255'd0, o_busy}, 256'd1);
        chk("rx_ready_wait", {255'd0, o_rx_ready}, 256'd0);
        i_rx_data  = 8'h5A;
        i_rx_valid = 1'b1;
        repeat (3) tick();
        i_rx_valid = 1'b0;
        chk("a_no_consume", o_core_a, A);

        push_res(RES);
        i_tx_ready = 1'b1;
        pulse_finish(RES);
        chk("tx_valid_j1", {255'd0, o_tx_valid}, 256'd1);
        chk("first_byte", {248'd0, o_tx_data}, 256'h11);
        chk("core_a_hold", o_core_a, A);
        repeat (4) tick();
        i_tx_ready = 1'b0;
        hold = o_tx_data;
        chk("stall_byte", {248'd0, hold}, 256'h55);
        repeat (5) begin
            tick();
            chk("stall_data", {248'd0, o_tx_data}, 256'h55);
            chk("stall_valid", {255'd0, o_tx_valid}, 256'd1);
        end
        i_tx_ready = 1'b1;
        wait_drain();
        chk("tx_valid_done", {255'd0, o_tx_valid}, 256'd0);
        chk("busy_done", {255'd0, o_busy}, 256'd0);
        chk("rx_ready_next", {255'd0, o_rx_ready}, 256'd1);

        pulse_finish('1);
        tick();
        chk("stray_finish_valid", {255'd0, o_tx_valid}, 256'd0);
        chk("stray_finish_busy", {255'd0, o_busy}, 256'd0);

`ifdef RSA_BRIDGE_REKEY_EN
        load(A2, 32, 1'b1);
        tick();
        chk("rekey_no_start", starts, 256'd1);
        chk("rekey_n", o_core_n, A2);
        chk("rekey_ready", {255'd0, o_rx_ready}, 256'd1);
`else
        expect_start(N, D, A2);
        load(A2, 32, 1'b1);
        chk("start2_k1", {255'd0, o_core_start}, 256'd1);
        push_res(RES2);
        pulse_finish(RES2);
        wait_drain();
        chk("two_starts", starts, 256'd2);
`endif

        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        load(N, 32, 1'b0);
        load(D, 8, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {255'd0, o_rx_ready}, 256'd0);
        chk("mid_rst_busy", {255'd0, o_busy}, 256'd0);
        chk("mid_rst_valid", {255'd0, o_tx_valid}, 256'd0);
        chk("mid_rst_n", o_core_n, 256'd0);
        chk("mid_rst_d", o_core_d, 256'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        expect_start(A2, D, A);
        load(A2, 32, 1'b1);
        load(D, 32, 1'b1);
        load(A, 32, 1'b1);
        chk("start3_k1", {255'd0, o_core_start}, 256'd1);
        push_res(RES);
        pulse_finish(RES);
        wait_drain();
        tick();
        chk("start_queue_empty", exp_n.size(), 256'd0);
`ifdef RSA_BRIDGE_REKEY_EN
        chk("total_starts", starts, 256'd2);
`else
        chk("total_starts", starts, 256'd3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
